// File: rtl/sram_nibble_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sram_nibble_loader: assembles bytes from a serial shift register and    |
// | writes them to consecutive SRAM addresses with ready handshaking.       |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module sram_nibble_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              q0,
  input  logic              q1,
  input  logic              q2,
  input  logic              q3,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [1:0]        r_bit_cnt;
  logic              r_strobe;
  logic              r_phase;
  logic              r_pending;
  logic              r_overrun;
  logic              r_busy;
  logic              r_done;
  logic [3:0]        r_hi_nib;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;

  logic [3:0]        w_nibble;
  logic              w_accept;
  logic              w_last;
  logic              w_byte_done;

  // q3 holds the first-received bit, so it lands in the nibble MSB
  assign w_nibble    = {q3, q2, q1, q0};
  assign w_accept    = r_pending & mem_ready;
  assign w_last      = (r_addr == c_last_addr);
  assign w_byte_done = r_strobe & r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 2'd0;
      r_strobe  <= 1'b0;
      r_phase   <= 1'b0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi_nib  <= 4'd0;
      r_addr    <= '0;
      r_data    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_COLLECT;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_bit_cnt <= 2'd0;
            r_strobe  <= 1'b0;
            r_phase   <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_addr    <= '0;
          end
        end
        S_COLLECT: begin
          if (bit_valid) begin
            r_bit_cnt <= r_bit_cnt + 2'd1;
          end
          r_strobe <= bit_valid && (r_bit_cnt == 2'd3);
          if (r_strobe) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_hi_nib <= w_nibble;
            end
          end
          // A byte completing alongside the final acceptance has nowhere to go
          if (w_accept && w_last) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pending <= 1'b0;
          end else if (w_byte_done && (!r_pending || w_accept)) begin
            r_data    <= {r_hi_nib, w_nibble};
            r_pending <= 1'b1;
          end else if (w_byte_done) begin
            r_overrun <= 1'b1;
          end else if (w_accept) begin
            r_pending <= 1'b0;
          end
          if (w_accept && !w_last) begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we   = r_pending;
  assign mem_addr = r_addr;
  assign mem_data = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sram_nibble_loader.sv
`default_nettype none
// Bench for sram_nibble_loader: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a bit-history model.
module tb_sram_nibble_loader;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       din = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] sr = 4'd0;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;

  sram_nibble_loader #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .q0(sr[0]), .q1(sr[1]), .q2(sr[2]), .q3(sr[3]),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // upstream shift register: newest bit in q0
  always @(posedge clk) if (bit_valid) sr <= {sr[2:0], din};

  // model: bytes are simply every 8 counted bits, MSB first, ready one edge later
  bit         m_ok = 1'b0;
  int         m_st = 0;        // 0 idle, 1 collect, 2 done
  bit         m_we = 1'b0;
  logic [3:0] m_addr = 4'd0;
  logic [7:0] m_data = 8'd0;
  bit         m_ovr = 1'b0;
  int         m_nbits = 0;
  logic [7:0] m_hist = 8'd0;
  bit         m_due = 1'b0;
  logic [7:0] m_due_byte = 8'd0;
  bit         acc, was_we, fin;
  logic [7:0] fb;

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1'b1; m_st = 0; m_we = 1'b0; m_addr = 4'd0; m_data = 8'd0;
      m_ovr = 1'b0; m_nbits = 0; m_due = 1'b0;
    end else if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_we = 1'b0; m_addr = 4'd0; m_ovr = 1'b0; m_nbits = 0; m_due = 1'b0;
      end
    end else begin
      acc = m_we && mem_ready;
      was_we = m_we;
      fin = m_due;
      fb = m_due_byte;
      m_due = 1'b0;
      if (acc) begin
        m_we = 1'b0;
        if (m_addr == 4'(DEPTH - 1)) begin
          m_st = 2;
          fin = 1'b0;
        end else begin
          m_addr = m_addr + 4'd1;
        end
      end
      if (fin) begin
        if (!was_we || acc) begin
          m_data = fb;
          m_we = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (m_st == 1 && bit_valid) begin
        m_hist = {m_hist[6:0], din};
        m_nbits++;
        if (m_nbits % 8 == 0) begin
          m_due = 1'b1;
          m_due_byte = m_hist;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1 && mem_ready === 1'b1) wr_cnt++;
    if (m_ok) begin
      total++;
      if ({mem_we, mem_addr, mem_data, busy, done, overrun} !==
          {m_we, m_addr, m_data, (m_st == 1), (m_st == 2), m_ovr}) begin
        bad++;
        $display("FAIL model t=%0t got we=%b addr=%0d data=%h busy=%b done=%b ovr=%b, want we=%b addr=%0d data=%h busy=%b done=%b ovr=%b",
                 $time, mem_we, mem_addr, mem_data, busy, done, overrun,
                 m_we, m_addr, m_data, (m_st == 1), (m_st == 2), m_ovr);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bit_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bit_valid = 1'b1;
      din = b[i];
      tick();
    end
  endtask

  int base;

  initial begin
    // basic write with ready high
    do_reset();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'h00);
    chk("rst_flags", 32'({busy, done, overrun}), 32'd0);
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    send(8'hA7);
    bit_valid = 1'b0;
    tick();
    chk("a7_we", 32'(mem_we), 32'd1);
    chk("a7_data", 32'(mem_data), 32'hA7);
    chk("a7_addr", 32'(mem_addr), 32'd0);
    tick();
    chk("a7_we_off", 32'(mem_we), 32'd0);
    chk("a7_addr_next", 32'(mem_addr), 32'd1);

    // write held while ready is low
    do_reset();
    do_start();
    mem_ready = 1'b0;
    send(8'hA7);
    bit_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) mem_ready = 1'b1;
      chk("hold_we", 32'(mem_we), 32'd1);
      chk("hold_data", 32'(mem_data), 32'hA7);
      chk("hold_addr", 32'(mem_addr), 32'd0);
    end
    tick();
    chk("hold_release", 32'({mem_we, mem_addr}), 32'h01);

    // overrun while stalled
    do_reset();
    do_start();
    mem_ready = 1'b0;
    send(8'h3C);
    send(8'h5A);
    bit_valid = 1'b0;
    tick();
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_data", 32'(mem_data), 32'h3C);
    base = wr_cnt;
    mem_ready = 1'b1;
    tick();
    chk("ovr_after", 32'({mem_we, mem_addr}), 32'h01);
    tick();
    chk("ovr_one_write", 32'(wr_cnt - base), 32'd1);

    // full load of DEPTH bytes then extra bits are ignored
    do_reset();
    do_start();
    mem_ready = 1'b1;
    base = wr_cnt;
    for (int n = 0; n < DEPTH; n++) send(8'($urandom));
    bit_valid = 1'b0;
    repeat (3) tick();
    chk("full_done", 32'({busy, done}), 32'h1);
    chk("full_addr", 32'(mem_addr), 32'd15);
    chk("full_writes", 32'(wr_cnt - base), 32'd16);
    send(8'hFF);
    bit_valid = 1'b0;
    repeat (3) tick();
    chk("done_no_write", 32'(wr_cnt - base), 32'd16);
    chk("done_we", 32'(mem_we), 32'd0);

    // reset abandons a stalled write
    do_reset();
    do_start();
    mem_ready = 1'b1;
    for (int n = 0; n < 4; n++) send(8'(n + 1));
    bit_valid = 1'b0;
    repeat (2) tick();
    mem_ready = 1'b0;
    send(8'h96);
    bit_valid = 1'b0;
    tick();
    chk("b5_pending", 32'({mem_we, mem_addr, mem_data}), 32'h1496);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("b5_reset", 32'({mem_we, mem_addr, busy, done}), 32'd0);
    do_start();
    mem_ready = 1'b1;
    send(8'h5C);
    bit_valid = 1'b0;
    tick();
    chk("b5_restart", 32'({mem_we, mem_addr, mem_data}), 32'h105C);

    // restart from DONE clears overrun
    do_reset();
    do_start();
    mem_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    bit_valid = 1'b0;
    tick();
    chk("re_ovr", 32'(overrun), 32'd1);
    mem_ready = 1'b1;
    for (int n = 0; n < DEPTH - 1; n++) send(8'($urandom));
    bit_valid = 1'b0;
    repeat (3) tick();
    chk("re_done_ovr", 32'({done, overrun}), 32'h3);
    do_start();
    chk("re_start", 32'({busy, done, overrun}), 32'h4);
    send(8'hE4);
    bit_valid = 1'b0;
    tick();
    chk("re_write", 32'({mem_we, mem_addr, mem_data}), 32'h10E4);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 19) == 0);
      bit_valid = ($urandom_range(0, 9) < 7);
      din       = 1'($urandom);
      mem_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    do_reset();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sram_nibble_loader.md
SRAM_NIBBLE_LOADER -- requirements
Module: sram_nibble_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of bytes written per load (2..256).
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the mem_addr width; DEPTH <= 2**ADDR_W.
REQ-003 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port reset: input, 1 bit, synchronous, active-high reset.
REQ-005 Port start: input, 1 bit, begins a load from IDLE or DONE.
REQ-006 Port bit_valid: input, 1 bit, high in every cycle whose closing edge shifts a new bit into the upstream 4-bit shift register.
REQ-007 Ports q0, q1, q2, q3: inputs, 1 bit each, parallel outputs of the upstream shift register; q0 is the newest bit, q3 the oldest.
REQ-008 Port mem_ready: input, 1 bit, SRAM accepts the write in any cycle where mem_we and mem_ready are both high.
REQ-009 Port mem_we: output, 1 bit, write request.
REQ-010 Port mem_addr: output, ADDR_W bits, write address.
REQ-011 Port mem_data: output, 8 bits, write data.
REQ-012 Port busy: output, 1 bit, high in COLLECT.
REQ-013 Port done: output, 1 bit, high in DONE.
REQ-014 Port overrun: output, 1 bit, sticky error flag.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT and DONE; IDLE->COLLECT on start; COLLECT->DONE on acceptance of the write to address DEPTH-1; DONE->COLLECT on start.
REQ-016 Entering COLLECT SHALL clear the bit counter, nibble phase, mem_addr, the pending flag and overrun.
REQ-017 In COLLECT a 2-bit bit counter SHALL increment on each edge with bit_valid=1 and wrap 3->0.
REQ-018 On the edge where the counter wraps 3->0, the block SHALL set a one-cycle capture strobe.
REQ-019 In the strobe cycle the block SHALL latch nibble {q3,q2,q1,q0}, so the first-received bit is the MSB.
REQ-020 bit_valid in the strobe cycle SHALL count as bit 1 of the next nibble, giving gap-free streaming.
REQ-021 The first captured nibble SHALL go to byte[7:4] and the second to byte[3:0]; the nibble phase toggles on every capture.
REQ-022 Completion of a byte SHALL load mem_data and set the pending flag on the same edge; mem_we equals the pending flag.
REQ-023 mem_we, mem_data and mem_addr SHALL stay stable while mem_we=1 and mem_ready=0.
REQ-024 On an edge with mem_we=1 and mem_ready=1, pending SHALL clear and mem_addr SHALL increment; mem_addr SHALL NOT increment after the write to address DEPTH-1.
REQ-025 A byte completing while pending=1 and mem_ready=0 SHALL be dropped and SHALL set overrun.
REQ-026 A byte completing on the same edge as an acceptance SHALL be loaded with pending held at 1, with no overrun.
REQ-027 bit_valid SHALL be ignored in IDLE and DONE, and start SHALL be ignored in COLLECT.
REQ-028 mem_ready SHALL be ignored when mem_we=0.

Reset
REQ-029 reset SHALL take priority over all inputs on the same edge, including start.
REQ-030 After reset the state SHALL be IDLE, with mem_we=0, mem_addr=0, mem_data=0x00, busy=0, done=0, overrun=0, and the counters and phase cleared.
REQ-031 reset asserted mid-load SHALL abandon any pending write immediately, with mem_we=0 on the next cycle.

Verification
REQ-032 Scenario: reset, start, stream bits 1,0,1,0,0,1,1,1 with mem_ready=1 -> mem_we pulses one cycle with mem_data=0xA7 and mem_addr=0, then mem_addr=1.
REQ-033 Scenario: as REQ-032 but mem_ready=0 for 3 cycles -> mem_we held 4 cycles with mem_data=0xA7 and mem_addr=0 stable, then mem_addr increments.
REQ-034 Scenario: mem_ready=0 continuously while streaming 16 bits 0x3C then 0x5A -> overrun=1, mem_data stays 0x3C, and after mem_ready=1 one write occurs.
REQ-035 Scenario: continuous bit_valid for DEPTH=16 bytes with mem_ready=1 -> 16 writes at addresses 0..15, then done=1, busy=0; further bits produce no mem_we.
REQ-036 Scenario: reset during the write of byte 5 with mem_ready=0 -> next cycle mem_we=0, mem_addr=0, state IDLE; a following start writes from address 0.
REQ-037 Scenario: start asserted in DONE -> busy=1, overrun cleared, and the next byte is written to address 0.
